// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the program-memory port arbiter.
// Grant vectors are one-hot with the bit positions given below.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StAck
  } arb_state_e;

  typedef enum logic {
    GCpu,
    GDbg
  } grant_e;

  localparam int unsigned GntCpuIdx = 0;
  localparam int unsigned GntDbgIdx = 1;

  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 3;
  localparam int unsigned LatCntW  = 2;

  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat >= RdLatMin) && (lat <= RdLatMax);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Tie-break between the CPU and debug ports with a starvation guard for debug.
// The grant is combinational and only valid while arb_en (FSM idle) is high.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       arb_en,
  input  logic       cpu_req,
  input  logic       dbg_req,
  output logic [1:0] gnt
);

  localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);

  logic [StreakW-1:0] streak_q, streak_d;
  logic               force_dbg;
  logic               gnt_cpu;
  logic               gnt_dbg;

  always_comb begin
    force_dbg = dbg_req && (streak_q == StreakMax);
    gnt_dbg   = arb_en && dbg_req && (!cpu_req || force_dbg);
    gnt_cpu   = arb_en && cpu_req && !gnt_dbg;

    gnt            = '0;
    gnt[GntCpuIdx] = gnt_cpu;
    gnt[GntDbgIdx] = gnt_dbg;

    // Streak only tracks CPU wins taken while debug was left waiting.
    streak_d = streak_q;
    if (arb_en) begin
      if (!dbg_req || gnt_dbg) begin
        streak_d = '0;
      end else if (gnt_cpu && (streak_q != StreakMax)) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous memory between the CPU and debug/loader ports,
// one access at a time, with all outputs registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [15:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_readout,
  output logic              busy
);

  if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_bad
    $error("mem_port_arbiter: RD_LAT must be in 1..3");
  end

  arb_state_e          state_q, state_d;
  grant_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LatCntW-1:0]  lat_cnt_q, lat_cnt_d;

  logic                cpu_ack_q, cpu_ack_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rden_q, mem_rden_d;
  logic                mem_wren_q, mem_wren_d;
  logic                busy_q, busy_d;

  logic [1:0]          gnt;
  logic                issue_next;
  logic                capture;

  // Upper address bits are deliberately dropped: addresses alias modulo 2**ADDR_W.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr, dbg_addr};

  mem_arb_grant #(
    .MAX_STREAK (MAX_STREAK)
  ) u_grant (
    .Clk     (Clk),
    .Reset   (Reset),
    .arb_en  (state_q == StIdle),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .gnt     (gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lat_cnt_d = lat_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (gnt != '0) begin
          state_d = StIssue;
          if (gnt[GntDbgIdx]) begin
            owner_d = GDbg;
            we_d    = dbg_we;
            addr_d  = dbg_addr[ADDR_W-1:0];
            wdata_d = dbg_wdata;
          end else begin
            owner_d = GCpu;
            we_d    = cpu_we;
            addr_d  = cpu_addr[ADDR_W-1:0];
            wdata_d = cpu_wdata;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StAck;
        end else begin
          state_d   = StWait;
          lat_cnt_d = LatCntW'(RD_LAT - 1);
        end
      end
      StWait: begin
        if (lat_cnt_q == '0) begin
          state_d = StAck;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are computed from next state so the registered copies line up with the FSM.
  always_comb begin
    issue_next  = (state_d == StIssue);
    capture     = (state_q == StWait) && (lat_cnt_q == '0);

    mem_rden_d  = issue_next && !we_d;
    mem_wren_d  = issue_next && we_d;
    mem_addr_d  = issue_next ? addr_d : mem_addr_q;
    mem_wdata_d = issue_next ? wdata_d : mem_wdata_q;

    cpu_ack_d   = (state_d == StAck) && (owner_d == GCpu);
    dbg_ack_d   = (state_d == StAck) && (owner_d == GDbg);

    cpu_rdata_d = (capture && (owner_q == GCpu)) ? mem_readout : cpu_rdata_q;
    dbg_rdata_d = (capture && (owner_q == GDbg)) ? mem_readout : dbg_rdata_q;

    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      owner_q     <= GCpu;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt_q   <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rden_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_cnt_q   <= lat_cnt_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rden_q  <= mem_rden_d;
      mem_wren_q  <= mem_wren_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rden  = mem_rden_q;
  assign mem_wren  = mem_wren_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: directed timing cases plus random two-port traffic
// checked against a serialized memory-image model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 16;
  localparam int RD_LAT     = 2;
  localparam int MAX_STREAK = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0]       cpu_addr, dbg_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic              cpu_ack, dbg_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_readout;
  logic              mem_rden, mem_wren, busy;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .MAX_STREAK (MAX_STREAK)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_ack     (dbg_ack),
    .dbg_rdata   (dbg_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_readout (mem_readout),
    .busy        (busy)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } xact_t;

  xact_t       cpu_q[$];
  xact_t       dbg_q[$];
  bit          ack_log[$];
  logic [15:0] ref_mem [1024];
  logic [15:0] tb_mem  [1024];
  logic [15:0] rd_pipe [RD_LAT];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  // Synchronous memory with RD_LAT cycles from the rden cycle to valid readout.
  always @(posedge Clk) begin
    if (mem_wren) tb_mem[mem_addr] = mem_wdata;
    rd_pipe[0] <= mem_rden ? tb_mem[mem_addr] : 16'hDEAD;
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_readout = rd_pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic score(input bit port, input logic [15:0] rdata);
    xact_t x;
    bit    have;
    have = port ? (dbg_q.size() != 0) : (cpu_q.size() != 0);
    check(port ? "dbg_ack_expected" : "cpu_ack_expected", have, 1);
    if (have) begin
      if (port) x = dbg_q.pop_front();
      else      x = cpu_q.pop_front();
      if (x.we) ref_mem[x.addr[ADDR_W-1:0]] = x.wdata;
      else check(port ? "dbg_rdata" : "cpu_rdata", rdata, ref_mem[x.addr[ADDR_W-1:0]]);
    end
  endtask

  // Monitor: retire one expected transaction per ack, in service order.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (mem_rden || mem_wren) check("rden_wren_exclusive", mem_rden && mem_wren, 0);
      if (cpu_ack || dbg_ack) check("single_ack", cpu_ack && dbg_ack, 0);
      if (cpu_ack) begin ack_log.push_back(1'b0); score(1'b0, cpu_rdata); end
      if (dbg_ack) begin ack_log.push_back(1'b1); score(1'b1, dbg_rdata); end
    end
  end

  // Issue one request, hold it until ack, drop it on the ack edge. lat = ack cycle + 1.
  task automatic do_xact(input bit port, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, output int lat);
    bit    seen;
    xact_t x;
    x.we = we; x.addr = addr; x.wdata = wd;
    seen = 1'b0;
    if (port) begin
      dbg_q.push_back(x); dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
    end else begin
      cpu_q.push_back(x); cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    end
    lat = 0;
    while (!seen && lat < 200) begin
      @(negedge Clk);
      lat++;
      seen = port ? dbg_ack : cpu_ack;
    end
    check(port ? "dbg_done" : "cpu_done", seen, 1);
    @(posedge Clk); #1;
    if (port) dbg_req = 1'b0;
    else      cpu_req = 1'b0;
  endtask

  task automatic rand_xact(input bit port);
    int          lat;
    logic [15:0] a;
    a = 16'($urandom) & 16'h0C07;
    do_xact(port, 1'($urandom), a, 16'($urandom), lat);
    repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat2, acks;
    logic [15:0] saved;
    logic [7:0]  order;

    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    for (int a = 0; a < 1024; a++) begin
      ref_mem[a] = init_word(a);
      tb_mem[a]  = init_word(a);
    end
    #1 Reset = 1'b1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dbg_ack", dbg_ack, 0);
    check("rst_mem_rden", mem_rden, 0);
    check("rst_mem_wren", mem_wren, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;

    // CPU write, with the memory-side strobe checked in the issue cycle.
    fork
      do_xact(1'b0, 1'b1, 16'h0012, 16'hBEEF, lat);
      begin
        @(posedge Clk); #2;
        check("wr_issue_wren", mem_wren, 1);
        check("wr_issue_rden", mem_rden, 0);
        check("wr_issue_addr", mem_addr, 10'h012);
        check("wr_issue_wdata", mem_wdata, 16'hBEEF);
      end
    join
    check("wr_latency", lat, 3);

    // CPU read; address changes during WAIT must not disturb the access.
    fork
      do_xact(1'b0, 1'b0, 16'h0012, 16'h0000, lat);
      begin
        @(posedge Clk); #2;
        check("rd_issue_rden", mem_rden, 1);
        check("rd_issue_addr", mem_addr, 10'h012);
        @(posedge Clk); #2;
        cpu_addr = 16'h0055;
        @(negedge Clk);
        check("rd_wait_addr", mem_addr, 10'h012);
        check("rd_wait_busy", busy, 1);
      end
    join
    check("rd_latency", lat, 3 + RD_LAT);
    check("rd_data", cpu_rdata, 16'hBEEF);

    // Simultaneous requests: CPU first, debug right after the following idle cycle.
    fork
      do_xact(1'b0, 1'b1, 16'h0030, 16'h1111, lat);
      do_xact(1'b1, 1'b1, 16'h0031, 16'h2222, lat2);
    join
    check("tie_cpu_latency", lat, 3);
    check("tie_dbg_latency", lat2, 6);

    // Starvation guard: CPU holding req gets MAX_STREAK grants, then debug, then CPU.
    repeat (2) begin @(posedge Clk); #1; end
    ack_log.delete();
    fork
      begin
        xact_t x;
        x.we = 1'b1; x.addr = 16'h0020; x.wdata = 16'hA5A5;
        for (int i = 0; i < MAX_STREAK + 1; i++) cpu_q.push_back(x);
        cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'hA5A5; cpu_req = 1'b1;
        acks = 0;
        for (int c = 0; c < 300 && acks < MAX_STREAK + 1; c++) begin
          @(negedge Clk);
          if (cpu_ack) acks++;
        end
        @(posedge Clk); #1;
        cpu_req = 1'b0;
        check("streak_cpu_acks", acks, MAX_STREAK + 1);
      end
      do_xact(1'b1, 1'b1, 16'h0021, 16'h5A5A, lat2);
    join
    check("streak_log_len", ack_log.size(), MAX_STREAK + 2);
    order = '0;
    foreach (ack_log[i]) if (i < 8) order[i] = ack_log[i];
    check("streak_order", order, 8'b0001_0000);
    check("streak_dbg_latency", lat2, 3 * MAX_STREAK + 3);

    // Address aliasing across ports; debug read data must stay put.
    do_xact(1'b1, 1'b1, 16'h0400, 16'h1234, lat);
    saved = dbg_rdata;
    do_xact(1'b0, 1'b0, 16'h0000, 16'h0000, lat);
    check("alias_data", cpu_rdata, 16'h1234);
    check("alias_dbg_rdata_kept", dbg_rdata, saved);

    // Reset during WAIT abandons the read with no ack.
    cpu_we = 1'b0; cpu_addr = 16'h0012; cpu_req = 1'b1;
    @(posedge Clk); #1;
    check("mr_issue_rden", mem_rden, 1);
    @(posedge Clk); #1;
    check("mr_wait_busy", busy, 1);
    #2 Reset = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("mr_rden", mem_rden, 0);
    check("mr_busy", busy, 0);
    check("mr_cpu_ack", cpu_ack, 0);
    check("mr_cpu_rdata", cpu_rdata, 0);
    @(posedge Clk); #1 Reset = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge Clk);
      if (cpu_ack || dbg_ack) acks++;
    end
    check("mr_no_ack", acks, 0);
    @(posedge Clk); #1;
    do_xact(1'b0, 1'b0, 16'h0012, 16'h0000, lat);
    check("mr_after_latency", lat, 3 + RD_LAT);
    check("mr_after_data", cpu_rdata, 16'hBEEF);

    // Random concurrent traffic from both ports.
    fork
      begin
        for (int i = 0; i < 40; i++) rand_xact(1'b0);
      end
      begin
        for (int j = 0; j < 40; j++) rand_xact(1'b1);
      end
    join
    repeat (4) @(posedge Clk);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("dbg_q_drained", dbg_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
